// File: rtl/calc_stack.sv
// calc_stack: button-driven accumulator calculator with undo history.
//
// Ports:
//   clk            single clock, rising edge
//   btnac          synchronous active-high reset
//   btnc / btnu    execute / undo buttons (level, act on rising edge)
//   btnl,btnr,btnd opcode select {btnl,btnr,btnd}
//   sw             operand B
//   led            accumulator value (registered)
//   busy           high while the shift-add multiply iterates
//   ovf            overflow flag of the last completed operation
//   hist_cnt       number of valid undo-history entries
module calc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         btnac,
  input  logic                         btnc,
  input  logic                         btnu,
  input  logic                         btnl,
  input  logic                         btnr,
  input  logic                         btnd,
  input  logic [WIDTH-1:0]             sw,
  output logic [WIDTH-1:0]             led,
  output logic                         busy,
  output logic                         ovf,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MCW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   btnc_q, btnu_q;
  logic [CW-1:0]          hist_cnt_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [WIDTH-1:0]       hist_q [DEPTH];

  logic [2*WIDTH-1:0]     mcand_q, prod_q, prod_nxt;
  logic [WIDTH-1:0]       mplier_q;
  logic [MCW-1:0]         mcnt_q;

  logic [2:0]             op;
  logic                   exec_press, undo_press;
  logic                   push, pop, mul_start, mul_step;
  logic [PW-1:0]          ptr_inc, ptr_dec;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_ovf;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  assign op         = {btnl, btnr, btnd};
  assign exec_press = btnc & ~btnc_q;
  assign undo_press = btnu & ~btnu_q;

  // Circular history: wr_ptr_q is the next free slot, top of stack is one below.
  assign ptr_inc = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
  assign ptr_dec = (wr_ptr_q == '0) ? PW'(DEPTH-1) : wr_ptr_q - 1'b1;

  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = acc_q;
    alu_ovf = 1'b0;
    unique case (op)
      3'b000: alu_res = acc_q >> sw[SHW-1:0];
      3'b001: alu_res = acc_q << sw[SHW-1:0];
      3'b010: begin
        alu_res = acc_q + sw;
        alu_ovf = add_ovf(acc_q, sw, alu_res);
      end
      3'b011: begin
        alu_res = acc_q - sw;
        alu_ovf = sub_ovf(acc_q, sw, alu_res);
      end
      3'b100: alu_res = acc_q;
      3'b101: alu_res = ~(acc_q | sw);
      3'b110: alu_res = ~(acc_q & sw);
      3'b111: alu_res = acc_q ^ sw;
      default: alu_res = acc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    pop       = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exec_press) begin
          if (op == 3'b100) begin
            state_d   = MUL;
            mul_start = 1'b1;
          end else begin
            acc_d = alu_res;
            ovf_d = alu_ovf;
            push  = 1'b1;
          end
        end else if (undo_press && (hist_cnt_q != '0)) begin
          acc_d = hist_q[ptr_dec];
          ovf_d = 1'b0;
          pop   = 1'b1;
        end
      end
      MUL: begin
        mul_step = 1'b1;
        // Last of WIDTH iterations: commit the finished product directly.
        if (mcnt_q == MCW'(WIDTH-1)) begin
          acc_d   = prod_nxt[WIDTH-1:0];
          ovf_d   = |prod_nxt[2*WIDTH-1:WIDTH];
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset also reloads the button history so a held button
  // does not fire on reset release.
  always_ff @(posedge clk) begin
    btnc_q <= btnc;
    btnu_q <= btnu;
    if (btnac) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      hist_cnt_q <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      if (push) begin
        wr_ptr_q <= ptr_inc;
        if (hist_cnt_q != CW'(DEPTH)) hist_cnt_q <= hist_cnt_q + 1'b1;
      end else if (pop) begin
        wr_ptr_q   <= ptr_dec;
        hist_cnt_q <= hist_cnt_q - 1'b1;
      end
    end
  end

  // Datapath: multiplier operands latched at the press, history storage.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mcand_q  <= {{WIDTH{1'b0}}, acc_q};
      mplier_q <= sw;
      prod_q   <= '0;
      mcnt_q   <= '0;
    end else if (mul_step) begin
      prod_q   <= prod_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      mcnt_q   <= mcnt_q + 1'b1;
    end
    if (push) hist_q[wr_ptr_q] <= acc_q;
  end

  assign led      = acc_q;
  assign busy     = (state_q == MUL);
  assign ovf      = ovf_q;
  assign hist_cnt = hist_cnt_q;

endmodule

// File: tb/tb_calc_stack.sv
module tb_calc_stack;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic clk = 1'b0;
  logic btnac = 1'b1, btnc = 1'b0, btnu = 1'b0;
  logic btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;
  logic [W-1:0]  sw = '0;
  logic [W-1:0]  led;
  logic          busy, ovf;
  logic [CW-1:0] hist_cnt;

  int n_chk = 0;
  int n_pass = 0;

  calc_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .btnac(btnac), .btnc(btnc), .btnu(btnu),
    .btnl(btnl), .btnr(btnr), .btnd(btnd), .sw(sw),
    .led(led), .busy(busy), .ovf(ovf), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_acc = '0;
  bit           m_ovf = 0;
  logic [W-1:0] m_hist[$];
  int           m_left = 0;
  logic [W-1:0] m_a, m_b;
  bit           pc = 0, pu = 0, m_started = 0;

  task automatic m_push(input logic [W-1:0] v);
    m_hist.push_back(v);
    if (m_hist.size() > D) void'(m_hist.pop_front());
  endtask

  task automatic m_alu(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r, output bit f);
    int s;
    int lim;
    lim = 1 << (W-1);
    f = 0;
    case (o)
      3'd0: r = a >> (int'(b) % W);
      3'd1: r = a << (int'(b) % W);
      3'd2: begin r = a + b; s = int'($signed(a)) + int'($signed(b)); f = (s >= lim) || (s < -lim); end
      3'd3: begin r = a - b; s = int'($signed(a)) - int'($signed(b)); f = (s >= lim) || (s < -lim); end
      3'd5: r = ~(a | b);
      3'd6: r = ~(a & b);
      3'd7: r = a ^ b;
      default: r = a;
    endcase
  endtask

  always @(posedge clk) begin
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    bit             f;
    if (btnac) begin
      m_acc = '0; m_ovf = 0; m_hist.delete(); m_left = 0; m_started = 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        p = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
        m_push(m_acc);
        m_acc = p[W-1:0];
        m_ovf = (p >> W) != 0;
      end
    end else if (btnc && !pc) begin
      if ({btnl, btnr, btnd} == 3'd4) begin
        m_a = m_acc; m_b = sw; m_left = W;
      end else begin
        m_alu({btnl, btnr, btnd}, m_acc, sw, r, f);
        m_push(m_acc);
        m_acc = r; m_ovf = f;
      end
    end else if (btnu && !pu) begin
      if (m_hist.size() > 0) begin
        m_acc = m_hist.pop_back();
        m_ovf = 0;
      end
    end
    pc = btnc;
    pu = btnu;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("led", led, m_acc);
      check("busy", busy, (m_left > 0));
      check("ovf", ovf, m_ovf);
      check("hist_cnt", hist_cnt, m_hist.size());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exec(input logic [2:0] o, input logic [W-1:0] v);
    @(negedge clk);
    {btnl, btnr, btnd} = o; sw = v; btnc = 1'b1;
    @(negedge clk);
    btnc = 1'b0;
  endtask

  task automatic undo();
    @(negedge clk); btnu = 1'b1;
    @(negedge clk); btnu = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); btnac = 1'b1;
    @(negedge clk); btnac = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2);
    btnac = 1'b0;
    check("rst_led", led, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_hist", hist_cnt, 0);

    exec(3'd2, 16'h285a);
    check("add_led", led, 16'h285a);
    check("add_ovf", ovf, 0);
    check("add_hist", hist_cnt, 1);
    exec(3'd7, 16'h04c8); check("xor_led", led, 16'h2c92);
    exec(3'd0, 16'h0005); check("srl_led", led, 16'h0164);
    exec(3'd5, 16'ha085); check("nor_led", led, 16'h5e1a);

    exec(3'd4, 16'h07fe);
    check("mul_busy_start", busy, 1);
    check("mul_led_hold", led, 16'h5e1a);
    sw = 16'hffff; {btnl, btnr, btnd} = 3'd2;
    cyc(3); btnc = 1'b1; btnu = 1'b1;
    cyc(2); btnc = 1'b0; btnu = 1'b0;
    cyc(9);
    check("mul_busy_mid", busy, 1);
    check("mul_led_mid", led, 16'h5e1a);
    cyc(1);
    check("mul_busy_last", busy, 1);
    cyc(1);
    check("mul_busy_done", busy, 0);
    check("mul_led", led, 16'h13cc);
    check("mul_ovf", ovf, 1);
    check("mul_hist_sat", hist_cnt, 4);

    exec(3'd1, 16'h0004); check("sll_led", led, 16'h3cc0);
    check("sll_ovf", ovf, 0);
    exec(3'd6, 16'hfa65); check("nand_led", led, 16'hc7bf);
    exec(3'd3, 16'hb2e4); check("sub_led", led, 16'h14db);
    check("sub_ovf", ovf, 0);
    exec(3'd0, 16'hfff0); check("srl_amt_low_bits", led, 16'h14db);

    do_reset();
    exec(3'd2, 16'h0001);
    exec(3'd2, 16'h7fff);
    check("add_ovf_led", led, 16'h8000);
    check("add_ovf_flag", ovf, 1);
    exec(3'd3, 16'h0001);
    check("sub_ovf_led", led, 16'h7fff);
    check("sub_ovf_flag", ovf, 1);

    do_reset();
    for (int i = 0; i < 6; i++) exec(3'd2, 16'h0001);
    check("six_add_led", led, 6);
    check("six_add_hist", hist_cnt, 4);
    undo(); check("undo1", led, 5);
    check("undo1_ovf", ovf, 0);
    undo(); check("undo2", led, 4);
    undo(); check("undo3", led, 3);
    undo(); check("undo4", led, 2);
    undo(); check("undo5_empty", led, 2);
    check("undo_hist", hist_cnt, 0);

    do_reset();
    @(negedge clk); {btnl, btnr, btnd} = 3'd2; sw = 16'h0001; btnc = 1'b1;
    cyc(10); btnc = 1'b0;
    cyc(1);
    check("hold_once", led, 1);
    @(negedge clk); btnc = 1'b1; btnu = 1'b1;
    @(negedge clk); btnc = 1'b0; btnu = 1'b0;
    check("simul_led", led, 2);
    check("simul_hist", hist_cnt, 2);

    @(negedge clk); {btnl, btnr, btnd} = 3'd4; sw = 16'h0003; btnc = 1'b1;
    cyc(5);
    btnac = 1'b1;
    @(negedge clk); btnac = 1'b0;
    check("abort_led", led, 0);
    check("abort_busy", busy, 0);
    check("abort_hist", hist_cnt, 0);
    {btnl, btnr, btnd} = 3'd2; sw = 16'h0001;
    cyc(5);
    check("held_after_rst", led, 0);
    btnc = 1'b0;
    cyc(1);
    exec(3'd2, 16'h0001);
    check("after_release", led, 1);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
